// File: rtl/avalon_enforcer_pkg.sv
// ============================================================================
// Module      : avalon_enforcer_pkg
// Description : State encoding and width helpers shared by the enforcer RTL.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package avalon_enforcer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IN_PACKET = 2'd1,
    DROP      = 2'd2
  } enforcer_state_t;

  // Empty field needs at least one bit even for single-byte beats.
  function automatic int empty_width(input int bytes);
    int w;
    w = $clog2(bytes);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int filler_empty(input int bytes);
    return bytes - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_st_if.sv
// ============================================================================
// Module      : avalon_st_if
// Description : Avalon-ST bundle with packet framing (sop/eop/empty).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 8
) ();

  localparam int EMPTY_WIDTH = avalon_enforcer_pkg::empty_width(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/avalon_packet_enforcer.sv
// ============================================================================
// Module      : avalon_packet_enforcer
// Description : Repairs Avalon-ST framing violations in flight (drop, close,
//               truncate) and flags each one. AVALON_ENFORCER_STATS_EN adds
//               saturating error counters; otherwise the counters read 0.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_packet_enforcer
  import avalon_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int MAX_PACKET_BEATS    = 256,
  parameter int COUNTER_WIDTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  avalon_st_if.slave               untrusted_msg,
  avalon_st_if.master              enforced_msg,
  output logic                     missing_sop_error,
  output logic                     double_sop_error,
  output logic                     length_error,
  output logic [COUNTER_WIDTH-1:0] missing_sop_count,
  output logic [COUNTER_WIDTH-1:0] double_sop_count,
  output logic [COUNTER_WIDTH-1:0] length_error_count
);

  localparam int DW    = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW    = empty_width(DATA_WIDTH_IN_BYTES);
  localparam int CNT_W = (MAX_PACKET_BEATS < 2) ? 1 : $clog2(MAX_PACKET_BEATS + 1);
  localparam logic [EW-1:0]  FILLER_EMPTY = EW'(filler_empty(DATA_WIDTH_IN_BYTES));
  localparam logic [CNT_W:0] MAX_CNT      = (CNT_W + 1)'(MAX_PACKET_BEATS);

  enforcer_state_t  r_state, w_state_next;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_valid, w_sop, w_eop, w_ready;
  logic [DW-1:0]    w_data;
  logic [EW-1:0]    w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_beat_cnt_next   = r_beat_cnt;
    w_cnt_inc         = {1'b0, r_beat_cnt} + (CNT_W + 1)'(1);
    w_valid           = 1'b0;
    w_sop             = 1'b0;
    w_eop             = 1'b0;
    w_data            = '0;
    w_empty           = '0;
    w_ready           = enforced_msg.ready;
    missing_sop_error = 1'b0;
    double_sop_error  = 1'b0;
    length_error      = 1'b0;

    if (untrusted_msg.valid) begin
      if (r_state == IN_PACKET && untrusted_msg.sop) begin
        // Close the open packet first; the new sop waits at the input.
        w_ready = 1'b0;
        w_valid = 1'b1;
        w_eop   = 1'b1;
        w_empty = FILLER_EMPTY;
        if (enforced_msg.ready) begin
          double_sop_error = 1'b1;
          w_state_next     = IDLE;
        end
      end else if (r_state == IN_PACKET || untrusted_msg.sop) begin
        w_valid = 1'b1;
        w_sop   = untrusted_msg.sop;
        w_eop   = untrusted_msg.eop;
        w_data  = untrusted_msg.data;
        w_empty = untrusted_msg.eop ? untrusted_msg.empty : '0;
        if (untrusted_msg.sop) begin
          if (untrusted_msg.eop) begin
            if (enforced_msg.ready) w_state_next = IDLE;
          end else if (MAX_PACKET_BEATS == 1) begin
            w_eop   = 1'b1;
            w_empty = '0;
            if (enforced_msg.ready) begin
              length_error = 1'b1;
              w_state_next = DROP;
            end
          end else if (enforced_msg.ready) begin
            w_beat_cnt_next = CNT_W'(1);
            w_state_next    = IN_PACKET;
          end
        end else begin
          if (enforced_msg.ready) w_beat_cnt_next = w_cnt_inc[CNT_W-1:0];
          if (untrusted_msg.eop) begin
            if (enforced_msg.ready) w_state_next = IDLE;
          end else if (MAX_PACKET_BEATS != 0 && w_cnt_inc == MAX_CNT) begin
            w_eop   = 1'b1;
            w_empty = '0;
            if (enforced_msg.ready) begin
              length_error = 1'b1;
              w_state_next = DROP;
            end
          end
        end
      end else begin
        // Non-sop beat outside a packet: swallow it regardless of the sink.
        w_ready = 1'b1;
        if (r_state == IDLE) begin
          missing_sop_error = 1'b1;
        end else if (untrusted_msg.eop) begin
          w_state_next = IDLE;
        end
      end
    end
  end

  assign untrusted_msg.ready = w_ready;
  assign enforced_msg.valid  = w_valid;
  assign enforced_msg.sop    = w_sop;
  assign enforced_msg.eop    = w_eop;
  assign enforced_msg.data   = w_data;
  assign enforced_msg.empty  = w_empty;

`ifdef AVALON_ENFORCER_STATS_EN
  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_missing_sop_cnt (
    .clk(clk), .rst(rst), .inc(missing_sop_error), .count(missing_sop_count)
  );
  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_double_sop_cnt (
    .clk(clk), .rst(rst), .inc(double_sop_error), .count(double_sop_count)
  );
  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_length_err_cnt (
    .clk(clk), .rst(rst), .inc(length_error), .count(length_error_count)
  );
`else
  assign missing_sop_count  = '0;
  assign double_sop_count   = '0;
  assign length_error_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_avalon_packet_enforcer.sv
// ============================================================================
// Module      : tb_avalon_packet_enforcer
// Description : Self-checking bench: directed vector table, reset/saturation
//               sequences and a randomized run against a packet-level model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_avalon_packet_enforcer;

  localparam int MAXB = 4;
`ifdef AVALON_ENFORCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       missing_sop_error, double_sop_error, length_error;
  logic [1:0] missing_sop_count, double_sop_count, length_error_count;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) src ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) sink ();

  avalon_packet_enforcer #(
    .DATA_WIDTH_IN_BYTES(4),
    .MAX_PACKET_BEATS   (MAXB),
    .COUNTER_WIDTH      (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .untrusted_msg     (src),
    .enforced_msg      (sink),
    .missing_sop_error (missing_sop_error),
    .double_sop_error  (double_sop_error),
    .length_error      (length_error),
    .missing_sop_count (missing_sop_count),
    .double_sop_count  (double_sop_count),
    .length_error_count(length_error_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
    if (!STATS) return 64'd0;
    return (n > 3) ? 64'd3 : 64'(n);
  endfunction

  typedef struct {
    logic v, s, e; logic [31:0] d; logic [1:0] em; logic rdy;
    logic ov, os, oe; logic [31:0] od; logic [1:0] oem; logic ir, ms, ds, le;
  } vec_t;

  function automatic vec_t row(input logic v, s, e, input logic [31:0] d, input logic [1:0] em,
                               input logic rdy, input logic ov, os, oe, input logic [31:0] od,
                               input logic [1:0] oem, input logic ir, ms, ds, le);
    vec_t x;
    x.v = v; x.s = s; x.e = e; x.d = d; x.em = em; x.rdy = rdy;
    x.ov = ov; x.os = os; x.oe = oe; x.od = od; x.oem = oem;
    x.ir = ir; x.ms = ms; x.ds = ds; x.le = le;
    return x;
  endfunction

  typedef struct packed { logic sop; logic eop; logic [1:0] empty; logic [31:0] data; } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int m_mode = 0;  // 0 outside packet, 1 inside packet, 2 discarding tail
  int m_n = 0, m_ms = 0, m_ds = 0, m_le = 0;

  // Packet-level reference: consumes each accepted input beat, emits expected output beats.
  task automatic model_accept(input beat_t b);
    beat_t o;
    if (m_mode == 1 && b.sop) begin
      o.sop = 1'b0; o.eop = 1'b1; o.empty = 2'd3; o.data = 32'd0;
      exp_q.push_back(o);
      m_ds++;
      m_mode = 0;
    end
    o = b;
    o.empty = b.eop ? b.empty : 2'd0;
    if (m_mode == 1) begin
      m_n++;
      if (b.eop) m_mode = 0;
      else if (MAXB != 0 && m_n == MAXB) begin o.eop = 1'b1; m_le++; m_mode = 2; end
      exp_q.push_back(o);
    end else if (b.sop) begin
      m_n = 1;
      if (b.eop) m_mode = 0;
      else if (MAXB == 1) begin o.eop = 1'b1; m_le++; m_mode = 2; end
      else m_mode = 1;
      exp_q.push_back(o);
    end else if (m_mode == 0) begin
      m_ms++;
    end else if (b.eop) begin
      m_mode = 0;
    end
  endtask

  task automatic drive(input logic v, s, e, input logic [31:0] d, input logic [1:0] em, input logic rdy);
    @(posedge clk);
    #1;
    src.valid = v; src.sop = s; src.eop = e; src.data = d; src.empty = em; sink.ready = rdy;
  endtask

  function automatic logic [63:0] obs();
    return 64'({sink.valid, sink.sop, sink.eop, sink.data, sink.empty,
                src.ready, missing_sop_error, double_sop_error, length_error});
  endfunction

  vec_t  tbl[$];
  beat_t cur;
  bit    have;
  int    ms_seen, ds_seen, le_seen, cyc;

  initial begin
    src.valid = 1'b0; src.sop = 1'b0; src.eop = 1'b0; src.data = '0; src.empty = '0;
    sink.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(sink.valid), 64'd0);
    check("reset_counters", 64'({missing_sop_count, double_sop_count, length_error_count}), 64'd0);

    // Legal 4-beat packet, idle cycle with junk on the bus
    tbl.push_back(row(1,1,0,32'hA1,2,1, 1,1,0,32'hA1,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hA2,0,1, 1,0,0,32'hA2,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hA3,1,1, 1,0,0,32'hA3,0,1,0,0,0));
    tbl.push_back(row(1,0,1,32'hA4,3,1, 1,0,1,32'hA4,3,1,0,0,0));
    tbl.push_back(row(0,1,1,32'hFF,3,1, 0,0,0,32'h0,0,1,0,0,0));
    // Two beats with no sop, then a legal packet
    tbl.push_back(row(1,0,0,32'hB1,0,0, 0,0,0,32'h0,0,1,1,0,0));
    tbl.push_back(row(1,0,1,32'hB2,2,1, 0,0,0,32'h0,0,1,1,0,0));
    tbl.push_back(row(1,1,0,32'hC1,0,1, 1,1,0,32'hC1,0,1,0,0,0));
    tbl.push_back(row(1,0,1,32'hC2,1,1, 1,0,1,32'hC2,1,1,0,0,0));
    // Double sop with sink stalled three cycles
    tbl.push_back(row(1,1,0,32'hD1,0,1, 1,1,0,32'hD1,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hD2,0,1, 1,0,0,32'hD2,0,1,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(row(1,1,0,32'hE1,0,0, 1,0,1,32'h0,3,0,0,0,0));
    tbl.push_back(row(1,1,0,32'hE1,0,1, 1,0,1,32'h0,3,0,0,1,0));
    // Second packet is 7 beats: beat 4 forced to eop, 5..7 dropped
    tbl.push_back(row(1,1,0,32'hE1,0,1, 1,1,0,32'hE1,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hE2,0,1, 1,0,0,32'hE2,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hE3,0,1, 1,0,0,32'hE3,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hE4,2,1, 1,0,1,32'hE4,0,1,0,0,1));
    tbl.push_back(row(1,0,0,32'hE5,0,0, 0,0,0,32'h0,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'hE6,0,1, 0,0,0,32'h0,0,1,0,0,0));
    tbl.push_back(row(1,0,1,32'hE7,1,1, 0,0,0,32'h0,0,1,0,0,0));
    tbl.push_back(row(1,1,1,32'hF1,1,1, 1,1,1,32'hF1,1,1,0,0,0));
    // Truncate again, then a sop ends the drop without any pulse
    tbl.push_back(row(1,1,0,32'h01,0,1, 1,1,0,32'h01,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'h02,0,1, 1,0,0,32'h02,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'h03,0,1, 1,0,0,32'h03,0,1,0,0,0));
    tbl.push_back(row(1,0,0,32'h04,0,1, 1,0,1,32'h04,0,1,0,0,1));
    tbl.push_back(row(1,1,0,32'h11,0,1, 1,1,0,32'h11,0,1,0,0,0));
    tbl.push_back(row(1,0,1,32'h12,2,1, 1,0,1,32'h12,2,1,0,0,0));
    // Pass-through stall
    tbl.push_back(row(1,1,0,32'h21,0,0, 1,1,0,32'h21,0,0,0,0,0));
    tbl.push_back(row(1,1,0,32'h21,0,1, 1,1,0,32'h21,0,1,0,0,0));
    tbl.push_back(row(1,0,1,32'h22,0,1, 1,0,1,32'h22,0,1,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].em, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(),
            64'({tbl[i].ov, tbl[i].os, tbl[i].oe, tbl[i].od, tbl[i].oem,
                 tbl[i].ir, tbl[i].ms, tbl[i].ds, tbl[i].le}));
    end
    drive(0,0,0,32'h0,0,1);
    @(negedge clk);
    check("tbl_ms_count", 64'(missing_sop_count), exp_cnt(2));
    check("tbl_ds_count", 64'(double_sop_count), exp_cnt(1));
    check("tbl_le_count", 64'(length_error_count), exp_cnt(2));

    // Asynchronous reset in the middle of a packet
    drive(1,1,0,32'h31,0,1);
    drive(1,0,0,32'h32,0,1);
    drive(1,0,0,32'h33,0,1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_counters", 64'({missing_sop_count, double_sop_count, length_error_count}), 64'd0);
    check("rst_idle_drop", 64'({sink.valid, src.ready, missing_sop_error}), 64'b011);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1,0,0,32'h34,0,1);
    @(negedge clk);
    check("post_rst_drop", obs(), 64'({1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    // Saturation: four more orphan beats, five in total
    for (int i = 0; i < 4; i++) begin
      drive(1,0,0,32'h40 + 32'(i),0,1);
      @(negedge clk);
      if (i == 2) check("ms_count_3", 64'(missing_sop_count), exp_cnt(3));
    end
    drive(0,0,0,32'h0,0,1);
    @(negedge clk);
    check("ms_count_sat", 64'(missing_sop_count), exp_cnt(5));

    // Randomized run against the packet-level model
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    have = 1'b0; ms_seen = 0; ds_seen = 0; le_seen = 0; cyc = 0;
    while (cyc < 4000 || (have && cyc < 4040)) begin
      @(posedge clk);
      #1;
      if (cyc < 4000 && !have && $urandom_range(0, 9) < 7) begin
        cur.sop   = ($urandom_range(0, 9) < 3);
        cur.eop   = ($urandom_range(0, 9) < 3);
        cur.empty = 2'($urandom_range(0, 3));
        cur.data  = $urandom;
        have = 1'b1;
      end
      src.valid = have;
      src.sop   = have & cur.sop;
      src.eop   = have & cur.eop;
      src.empty = have ? cur.empty : 2'd0;
      src.data  = have ? cur.data : 32'd0;
      sink.ready = (cyc >= 4000) ? 1'b1 : ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (!sink.valid)
        check("idle_zero", 64'({sink.sop, sink.eop, sink.empty, sink.data}), 64'd0);
      if (sink.valid && sink.ready) begin
        beat_t g;
        g.sop = sink.sop; g.eop = sink.eop; g.empty = sink.empty; g.data = sink.data;
        got_q.push_back(g);
      end
      ms_seen += int'(missing_sop_error);
      ds_seen += int'(double_sop_error);
      le_seen += int'(length_error);
      if (src.valid && src.ready) begin
        model_accept(cur);
        have = 1'b0;
      end
      cyc++;
    end
    check("rand_drain", 64'(have), 64'd0);
    drive(0,0,0,32'h0,0,1);
    @(negedge clk);
    check("rand_beats", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("rand_beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    check("rand_ms_pulses", 64'(ms_seen), 64'(m_ms));
    check("rand_ds_pulses", 64'(ds_seen), 64'(m_ds));
    check("rand_le_pulses", 64'(le_seen), 64'(m_le));
    check("rand_ms_count", 64'(missing_sop_count), exp_cnt(m_ms));
    check("rand_ds_count", 64'(double_sop_count), exp_cnt(m_ds));
    check("rand_le_count", 64'(length_error_count), exp_cnt(m_le));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
